checker_mode_scan: RTL and testbench

//  Mode-side responder of the checker start/end/irq/ack/error handshake: on a start request it walks one
//  4 KiB page as qword reads, hands each qword to the CPU via mode_data + mode_irq, waits for mode_ack,

---
 rtl/checker_mode_scan_pkg.sv | 31 +++
 rtl/checker_mode_scan_if.sv | 33 +++
 rtl/checker_scan_timer.sv | 27 ++
 rtl/checker_mode_scan.sv | 144 ++++++++++++++
 tb/tb_checker_mode_scan.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/checker_mode_scan_pkg.sv
// Shared encodings and address helpers for the checker single-page scan.
// States mirror the CHECKER_SCAN_ST_* encodings used by the checker top.
package checker_mode_scan_pkg;

   typedef enum logic [2:0] {
      CHECKER_SCAN_ST_IDLE     = 3'd0,
      CHECKER_SCAN_ST_REQ      = 3'd1,
      CHECKER_SCAN_ST_IRQ      = 3'd2,
      CHECKER_SCAN_ST_WAIT_ACK = 3'd3,
      CHECKER_SCAN_ST_DRAIN    = 3'd4
   } scan_state_t;

   localparam logic [1:0] CHECKER_MODE_SINGLE = 2'd1;

   function automatic logic [63:0] page_align(
      input logic [63:0] addr,
      input int          page_bits
   );
      logic [63:0] mask;
      mask = {64{1'b1}} << page_bits;
      return addr & mask;
   endfunction

   function automatic logic [63:0] qword_addr(
      input logic [63:0] base,
      input logic [63:0] idx
   );
      return base + (idx << 3);
   endfunction

endpackage

// File: rtl/checker_mode_scan_if.sv
// Control-side and read-port signals of the checker page scan.
// master: the scan engine; slave: control logic plus memory port.
interface checker_mode_scan_if;

   logic        mode_start;
   logic [63:0] mode_addr;
   logic        mode_end;
   logic [63:0] mode_data;
   logic        mode_irq;
   logic        mode_ack;
   logic        mode_error;

   logic        rd_req;
   logic [63:0] rd_addr;
   logic        rd_ack;
   logic [63:0] rd_data;
   logic        rd_err;

   modport master (
      input  mode_start, mode_addr, mode_ack,
      input  rd_ack, rd_data, rd_err,
      output mode_end, mode_data, mode_irq, mode_error,
      output rd_req, rd_addr
   );

   modport slave (
      output mode_start, mode_addr, mode_ack,
      output rd_ack, rd_data, rd_err,
      input  mode_end, mode_data, mode_irq, mode_error,
      input  rd_req, rd_addr
   );

endinterface

// File: rtl/checker_scan_timer.sv
// Read-timeout counter: cleared while idle, expires after limit enabled
// cycles. Only instantiated when CHECKER_SCAN_TIMEOUT_EN is defined.
module checker_scan_timer #(
   parameter int unsigned LIMIT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               enable,
   input  logic [LIMIT_W-1:0] limit,
   output logic               expired
);

   logic [LIMIT_W-1:0] cnt;

   // Counts cycles already spent waiting, so the limit-th cycle expires.
   assign expired = enable && (cnt == limit - LIMIT_W'(1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + LIMIT_W'(1);
      end
   end

endmodule

// File: rtl/checker_mode_scan.sv
// Single-page scan responder: reads a page qword by qword, irq/ack per qword.
// Optional read timeout enabled by defining CHECKER_SCAN_TIMEOUT_EN.
module checker_mode_scan
   import checker_mode_scan_pkg::*;
#(
   parameter int unsigned PAGE_QWORDS    = 512,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input logic                 sys_clk,
   input logic                 sys_rst,
   checker_mode_scan_if.master bus
);

   localparam int PAGE_BITS = $clog2(PAGE_QWORDS * 8);
   localparam int IDX_W     = $clog2(PAGE_QWORDS) + 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAGE_QWORDS - 1);

   scan_state_t      state, state_n;
   logic             start_q, start_edge;
   logic [IDX_W-1:0] idx, idx_n;
   logic [63:0]      base, base_n;
   logic [63:0]      addr_n, data_n;
   logic             req_n, irq_n, end_n, err_n;
   logic             timeout;

   assign start_edge = bus.mode_start & ~start_q;

`ifdef CHECKER_SCAN_TIMEOUT_EN
   logic tmo_en;

   assign tmo_en = (state == CHECKER_SCAN_ST_REQ) ||
                   (state == CHECKER_SCAN_ST_DRAIN);

   checker_scan_timer #(
      .LIMIT_W (32)
   ) u_timer (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .clear   (!tmo_en),
      .enable  (tmo_en),
      .limit   (32'(TIMEOUT_CYCLES)),
      .expired (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_n = state;
      idx_n   = idx;
      base_n  = base;
      addr_n  = bus.rd_addr;
      data_n  = bus.mode_data;
      req_n   = bus.rd_req;
      irq_n   = 1'b0;
      end_n   = 1'b0;
      err_n   = 1'b0;
      unique case (state)
         CHECKER_SCAN_ST_IDLE: begin
            if (start_edge) begin
               base_n  = page_align(bus.mode_addr, PAGE_BITS);
               idx_n   = '0;
               addr_n  = base_n;
               req_n   = 1'b1;
               state_n = CHECKER_SCAN_ST_REQ;
            end
         end
         CHECKER_SCAN_ST_REQ: begin
            if (bus.rd_err) begin
               req_n   = 1'b0;
               err_n   = 1'b1;
               state_n = CHECKER_SCAN_ST_IDLE;
            end else if (bus.rd_ack) begin
               data_n  = bus.rd_data;
               req_n   = 1'b0;
               irq_n   = 1'b1;
               state_n = CHECKER_SCAN_ST_IRQ;
            end else if (timeout) begin
               req_n   = 1'b0;
               err_n   = 1'b1;
               state_n = CHECKER_SCAN_ST_IDLE;
            end else if (!bus.mode_start) begin
               state_n = CHECKER_SCAN_ST_DRAIN;
            end
         end
         CHECKER_SCAN_ST_IRQ: begin
            state_n = CHECKER_SCAN_ST_WAIT_ACK;
         end
         CHECKER_SCAN_ST_WAIT_ACK: begin
            if (!bus.mode_start) begin
               state_n = CHECKER_SCAN_ST_IDLE;
            end else if (bus.mode_ack) begin
               if (idx == IDX_LAST) begin
                  end_n   = 1'b1;
                  state_n = CHECKER_SCAN_ST_IDLE;
               end else begin
                  idx_n   = idx + IDX_W'(1);
                  addr_n  = qword_addr(base, 64'(idx_n));
                  req_n   = 1'b1;
                  state_n = CHECKER_SCAN_ST_REQ;
               end
            end
         end
         CHECKER_SCAN_ST_DRAIN: begin
            // Aborted run: retire the outstanding read silently.
            if (bus.rd_ack || bus.rd_err || timeout) begin
               req_n   = 1'b0;
               state_n = CHECKER_SCAN_ST_IDLE;
            end
         end
         default: begin
            req_n   = 1'b0;
            state_n = CHECKER_SCAN_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state          <= CHECKER_SCAN_ST_IDLE;
         start_q        <= 1'b0;
         idx            <= '0;
         base           <= '0;
         bus.rd_req     <= 1'b0;
         bus.rd_addr    <= '0;
         bus.mode_data  <= '0;
         bus.mode_irq   <= 1'b0;
         bus.mode_end   <= 1'b0;
         bus.mode_error <= 1'b0;
      end else begin
         state          <= state_n;
         start_q        <= bus.mode_start;
         idx            <= idx_n;
         base           <= base_n;
         bus.rd_req     <= req_n;
         bus.rd_addr    <= addr_n;
         bus.mode_data  <= data_n;
         bus.mode_irq   <= irq_n;
         bus.mode_end   <= end_n;
         bus.mode_error <= err_n;
      end
   end

endmodule

// File: tb/tb_checker_mode_scan.sv
// Scoreboard bench for checker_mode_scan: full page, error, abort, restart,
// timeout (CHECKER_SCAN_TIMEOUT_EN, limit 16) and reset mid-run.
module tb_checker_mode_scan;

   logic sys_clk = 1'b0;
   logic sys_rst;

   always #5 sys_clk = ~sys_clk;

   checker_mode_scan_if bus();

   checker_mode_scan #(
      .PAGE_QWORDS    (512),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int irq_cnt  = 0;
   int end_cnt  = 0;
   int err_cnt  = 0;
   int excl_bad = 0;
   int s_irq, s_end, s_err;

   logic [63:0] addr_q[$];
   logic [63:0] data_q[$];

   always @(negedge sys_clk) begin
      if (bus.mode_irq)   irq_cnt++;
      if (bus.mode_end)   end_cnt++;
      if (bus.mode_error) err_cnt++;
      if (int'(bus.mode_irq) + int'(bus.mode_end) +
          int'(bus.mode_error) > 1) excl_bad++;
   end

   task automatic chk(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic snap();
      s_irq = irq_cnt;
      s_end = end_cnt;
      s_err = err_cnt;
   endtask

   task automatic chk_pulses(
      input string tag,
      input int    irqs,
      input int    ends,
      input int    errs
   );
      chk({tag, "_irqs"}, 64'(irq_cnt - s_irq), 64'(irqs));
      chk({tag, "_ends"}, 64'(end_cnt - s_end), 64'(ends));
      chk({tag, "_errs"}, 64'(err_cnt - s_err), 64'(errs));
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (!bus.rd_req && n < 20) begin
         tick();
         n++;
      end
      if (!bus.rd_req) chk({tag, "_wait"}, 64'(bus.rd_req), 64'd1);
   endtask

   task automatic chk_addr(input string tag);
      if (addr_q.size() == 0) chk({tag, "_q_empty"}, 64'd0, 64'd1);
      else chk(tag, bus.rd_addr, addr_q.pop_front());
   endtask

   task automatic do_qword(input logic [63:0] d);
      wait_req("req");
      chk_addr("rd_addr");
      bus.rd_ack  = 1'b1;
      bus.rd_data = d;
      data_q.push_back(d);
      tick();
      bus.rd_ack = 1'b0;
      chk("irq", 64'(bus.mode_irq), 64'd1);
      chk("req_drop", 64'(bus.rd_req), 64'd0);
      chk("mode_data", bus.mode_data, data_q.pop_front());
      tick();
      chk("irq_once", 64'(bus.mode_irq), 64'd0);
      bus.mode_ack = 1'b1;
      tick();
      bus.mode_ack = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst        = 1'b1;
      bus.mode_start = 1'b0;
      bus.mode_addr  = '0;
      bus.mode_ack   = 1'b0;
      bus.rd_ack     = 1'b0;
      bus.rd_data    = '0;
      bus.rd_err     = 1'b0;
      repeat (2) tick();
      sys_rst = 1'b0;
      tick();
      chk("rst_req", 64'(bus.rd_req), 64'd0);
      chk("rst_addr", bus.rd_addr, 64'd0);
      chk("rst_data", bus.mode_data, 64'd0);
      chk("rst_irq", 64'(bus.mode_irq), 64'd0);
      chk("rst_end", 64'(bus.mode_end), 64'd0);
      chk("rst_err", 64'(bus.mode_error), 64'd0);

      // Full page from an unaligned address
      snap();
      bus.mode_addr  = 64'h0000_0000_1234_5FFF;
      bus.mode_start = 1'b1;
      for (int i = 0; i < 512; i++)
         addr_q.push_back(64'h1234_5000 + 64'(i) * 8);
      tick();
      chk("first_req", 64'(bus.rd_req), 64'd1);
      for (int i = 0; i < 512; i++) do_qword(64'(i));
      chk("end_pulse", 64'(bus.mode_end), 64'd1);
      chk("last_data", bus.mode_data, 64'd511);
      tick();
      chk("end_once", 64'(bus.mode_end), 64'd0);
      chk("end_req", 64'(bus.rd_req), 64'd0);
      chk_pulses("page", 512, 1, 0);

      // Held start does not restart; fresh edge restarts at idx 0
      repeat (5) tick();
      chk("no_restart", 64'(bus.rd_req), 64'd0);
      bus.mode_start = 1'b0;
      tick();
      snap();
      bus.mode_addr  = 64'hFFFF_FFFF_FFFF_F123;
      bus.mode_start = 1'b1;
      for (int i = 0; i < 4; i++)
         addr_q.push_back(64'hFFFF_FFFF_FFFF_F000 + 64'(i) * 8);
      tick();
      chk("restart_req", 64'(bus.rd_req), 64'd1);
      for (int i = 0; i < 3; i++) do_qword(64'(100 + i));

      // Read error on qword 3, with a simultaneous ack
      wait_req("err_req");
      chk_addr("err_addr");
      bus.rd_err  = 1'b1;
      bus.rd_ack  = 1'b1;
      bus.rd_data = 64'h0BAD;
      tick();
      bus.rd_err = 1'b0;
      bus.rd_ack = 1'b0;
      chk("err_pulse", 64'(bus.mode_error), 64'd1);
      chk("err_no_irq", 64'(bus.mode_irq), 64'd0);
      chk("err_req", 64'(bus.rd_req), 64'd0);
      tick();
      chk("err_once", 64'(bus.mode_error), 64'd0);
      repeat (5) tick();
      chk("err_idle", 64'(bus.rd_req), 64'd0);
      chk("err_data", bus.mode_data, 64'd102);
      chk_pulses("err", 3, 0, 1);

      // Abort with read outstanding, ack arrives later
      bus.mode_start = 1'b0;
      tick();
      snap();
      bus.mode_addr  = 64'h2008;
      bus.mode_start = 1'b1;
      addr_q.push_back(64'h2000);
      tick();
      chk("drain_req", 64'(bus.rd_req), 64'd1);
      chk_addr("drain_addr");
      bus.mode_start = 1'b0;
      repeat (5) tick();
      chk("drain_hold", 64'(bus.rd_req), 64'd1);
      bus.rd_ack  = 1'b1;
      bus.rd_data = 64'hDEAD;
      tick();
      bus.rd_ack = 1'b0;
      chk("drain_drop", 64'(bus.rd_req), 64'd0);
      repeat (3) tick();
      chk("drain_data", bus.mode_data, 64'd102);
      chk_pulses("drain", 0, 0, 0);

      // Abort and ack in the same WAIT_ACK cycle
      snap();
      bus.mode_addr  = 64'h4000;
      bus.mode_start = 1'b1;
      addr_q.push_back(64'h4000);
      tick();
      wait_req("wa_req");
      chk_addr("wa_addr");
      bus.rd_ack  = 1'b1;
      bus.rd_data = 64'h44;
      tick();
      bus.rd_ack = 1'b0;
      chk("wa_irq", 64'(bus.mode_irq), 64'd1);
      tick();
      bus.mode_start = 1'b0;
      bus.mode_ack   = 1'b1;
      tick();
      bus.mode_ack = 1'b0;
      chk("wa_no_req", 64'(bus.rd_req), 64'd0);
      repeat (5) tick();
      chk("wa_idle", 64'(bus.rd_req), 64'd0);
      chk_pulses("wa", 1, 0, 0);

      // Unanswered read
      snap();
      bus.mode_addr  = 64'h8000;
      bus.mode_start = 1'b1;
      addr_q.push_back(64'h8000);
      tick();
      chk("tmo_req", 64'(bus.rd_req), 64'd1);
      chk_addr("tmo_addr");
`ifdef CHECKER_SCAN_TIMEOUT_EN
      repeat (15) tick();
      chk("tmo_early", 64'(bus.mode_error), 64'd0);
      chk("tmo_held", 64'(bus.rd_req), 64'd1);
      tick();
      chk("tmo_err", 64'(bus.mode_error), 64'd1);
      chk("tmo_drop", 64'(bus.rd_req), 64'd0);
      tick();
      chk_pulses("tmo", 0, 0, 1);
      bus.mode_start = 1'b0;
      tick();
`else
      repeat (40) tick();
      chk("notmo_held", 64'(bus.rd_req), 64'd1);
      bus.mode_start = 1'b0;
      tick();
      bus.rd_err = 1'b1;
      tick();
      bus.rd_err = 1'b0;
      chk("notmo_drop", 64'(bus.rd_req), 64'd0);
      tick();
      chk_pulses("notmo", 0, 0, 0);
`endif

      // Reset in the middle of a run
      bus.mode_addr  = 64'h0010_0000;
      bus.mode_start = 1'b1;
      addr_q.push_back(64'h0010_0000);
      tick();
      chk("mr_req", 64'(bus.rd_req), 64'd1);
      chk_addr("mr_addr");
      snap();
      sys_rst        = 1'b1;
      bus.mode_start = 1'b0;
      tick();
      chk("mr_drop", 64'(bus.rd_req), 64'd0);
      chk("mr_addr0", bus.rd_addr, 64'd0);
      sys_rst = 1'b0;
      repeat (3) tick();
      chk("mr_idle", 64'(bus.rd_req), 64'd0);
      chk_pulses("mr", 0, 0, 0);

      chk("exclusive", 64'(excl_bad), 64'd0);
      chk("addr_q_left", 64'(addr_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
